clk_div_select: RTL and testbench

Glitch-free programmable clock-divider stage that sits directly downstream of the fixed ripple divider. It runs entirely on the undivided CLK and produces one registered divided clock, clk_out, at /2, /4, /8 or /16. It also produces single-cycle rise/fall enable pulses for logic that stays on CLK. Ratio changes are requested over a valid/ready handshake and take effect only at a period boundary, so clk_out never shows a runt pulse.

---
 rtl/clk_div_select.sv | 133 +++++++++++++
 tb/tb_clk_div_select.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_select.sv
// clk_div_select: glitch-free /2, /4, /8, /16 divided clock generated on CLK.
// Ratio changes use a valid/ready handshake and are applied only where clk_out
// falls, which closes a full output period.
// Build option: define CLK_DIV_SELECT_PULSE_EN to build the rise/fall pulse
// flops; otherwise rise_pulse and fall_pulse are tied to 0.
module clk_div_select #(
    parameter logic [1:0] RESET_DIV = 2'd0
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [1:0] div_sel,
    input  logic       sel_valid,
    output logic       sel_ready,
    output logic       sel_done,
    output logic [1:0] active_div,
    output logic       clk_out,
    output logic       rise_pulse,
    output logic       fall_pulse
);

    localparam int unsigned CNT_W = 3;
    localparam int unsigned DIV_W = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } hs_state_t;

    hs_state_t        r_state;
    hs_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_half_max;
    logic [DIV_W-1:0] r_active_div;
    logic [DIV_W-1:0] w_active_nxt;
    logic [DIV_W-1:0] r_pend_div;
    logic [DIV_W-1:0] w_pend_nxt;
    logic             r_clk_out;
    logic             w_clk_nxt;
    logic             r_sel_done;
    logic             w_done_nxt;
    logic             w_toggle;
    logic             w_apply;

    // Terminal count of a half-period for the ratio currently in effect
    always_comb begin
        w_half_max = '0;
        case (r_active_div)
            2'd0:    w_half_max = CNT_W'(0);
            2'd1:    w_half_max = CNT_W'(1);
            2'd2:    w_half_max = CNT_W'(3);
            default: w_half_max = CNT_W'(7);
        endcase
    end

    // Next-state: half-period counter, clock level and request handshake
    always_comb begin
        w_toggle     = (r_cnt == w_half_max);
        w_apply      = w_toggle && r_clk_out && (r_state == ST_PEND);
        w_state_nxt  = r_state;
        w_pend_nxt   = r_pend_div;
        w_active_nxt = r_active_div;
        w_done_nxt   = 1'b0;
        w_cnt_nxt    = w_toggle ? '0 : CNT_W'(r_cnt + CNT_W'(1));
        w_clk_nxt    = w_toggle ? ~r_clk_out : r_clk_out;

        case (r_state)
            ST_IDLE: begin
                // Accepting on a falling edge only arms the request; it is
                // applied at the following fall.
                if (sel_valid) begin
                    w_state_nxt = ST_PEND;
                    w_pend_nxt  = div_sel;
                end
            end
            ST_PEND: begin
                if (w_apply) begin
                    w_state_nxt  = ST_IDLE;
                    w_active_nxt = r_pend_div;
                    w_done_nxt   = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_clk_out    <= 1'b0;
            r_active_div <= RESET_DIV;
            r_pend_div   <= '0;
            r_sel_done   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_clk_out    <= w_clk_nxt;
            r_active_div <= w_active_nxt;
            r_pend_div   <= w_pend_nxt;
            r_sel_done   <= w_done_nxt;
        end
    end

`ifdef CLK_DIV_SELECT_PULSE_EN
    logic r_rise_pulse;
    logic r_fall_pulse;

    // Edge pulses registered alongside clk_out so they align with its new level
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_rise_pulse <= 1'b0;
            r_fall_pulse <= 1'b0;
        end else begin
            r_rise_pulse <= w_toggle && !r_clk_out;
            r_fall_pulse <= w_toggle && r_clk_out;
        end
    end

    assign rise_pulse = r_rise_pulse;
    assign fall_pulse = r_fall_pulse;
`else
    assign rise_pulse = 1'b0;
    assign fall_pulse = 1'b0;
`endif

    assign sel_ready  = (r_state == ST_IDLE);
    assign sel_done   = r_sel_done;
    assign active_div = r_active_div;
    assign clk_out    = r_clk_out;

endmodule

// File: tb/tb_clk_div_select.sv
// Scoreboard bench for clk_div_select: a period-position model predicts every
// output after each CLK edge; a negedge monitor pops and compares.
module tb_clk_div_select;

    localparam logic [1:0] RST_DIV = 2'd0;

    logic       CLK = 1'b0;
    logic       reset;
    logic [1:0] div_sel;
    logic       sel_valid;
    logic       sel_ready;
    logic       sel_done;
    logic [1:0] active_div;
    logic       clk_out;
    logic       rise_pulse;
    logic       fall_pulse;

    clk_div_select #(.RESET_DIV(RST_DIV)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .div_sel    (div_sel),
        .sel_valid  (sel_valid),
        .sel_ready  (sel_ready),
        .sel_done   (sel_done),
        .active_div (active_div),
        .clk_out    (clk_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       ready;
        logic       done;
        logic [1:0] act;
        logic       clk;
        logic       rise;
        logic       fall;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks     = 0;
    int   n_errors     = 0;
    int   exp_done_cnt = 0;
    int   dut_done_cnt = 0;

    // Model: ratio code, edges elapsed in current output period, pending request
    int m_code;
    int m_e;
    bit m_pend;
    int m_pend_code;

    function automatic int half(input int code);
        return 1 << code;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_true(input string name, input bit cond);
        n_checks++;
        if (!cond) begin
            n_errors++;
            $display("FAIL %s: condition not reached at %0t", name, $time);
        end
    endtask

    task automatic model_reset();
        m_code      = int'(RST_DIV);
        m_e         = 0;
        m_pend      = 1'b0;
        m_pend_code = 0;
    endtask

    // Advance the model by one CLK edge using the inputs present at that edge
    task automatic model_edge(input logic v, input logic [1:0] d);
        exp_t x;
        bit   rise;
        bit   fall;
        bit   done;
        bit   accept;
        int   h;
        rise = 1'b0;
        fall = 1'b0;
        done = 1'b0;
        if (reset) begin
            model_reset();
        end else begin
            h      = half(m_code);
            accept = v && !m_pend;
            m_e++;
            if (m_e == h) rise = 1'b1;
            if (m_e == 2 * h) begin
                fall = 1'b1;
                m_e  = 0;
                if (m_pend) begin
                    m_code = m_pend_code;
                    m_pend = 1'b0;
                    done   = 1'b1;
                    exp_done_cnt++;
                end
            end
            if (accept) begin
                m_pend      = 1'b1;
                m_pend_code = int'(d);
            end
        end
        x.ready = !m_pend;
        x.done  = done;
        x.act   = 2'(m_code);
        x.clk   = (m_e >= half(m_code));
`ifdef CLK_DIV_SELECT_PULSE_EN
        x.rise  = rise;
        x.fall  = fall;
`else
        x.rise  = 1'b0;
        x.fall  = 1'b0;
`endif
        exp_q.push_back(x);
    endtask

    // Drive inputs for one edge, update model at the edge, return at edge+1
    task automatic tick(input logic v, input logic [1:0] d);
        sel_valid = v;
        div_sel   = d;
        @(posedge CLK);
        model_edge(v, d);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 2'($urandom));
    endtask

    task automatic wait_applied(input string name, input int limit);
        int i;
        i = 0;
        while (m_pend && i < limit) begin
            tick(1'b0, 2'($urandom));
            i++;
        end
        expect_true(name, !m_pend);
    endtask

    // Asynchronous reset between edges, checked before the next edge
    task automatic reset_mid();
        @(negedge CLK);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_rst_clk_out", 16'(clk_out), 16'd0);
        chk("async_rst_sel_ready", 16'(sel_ready), 16'd1);
        chk("async_rst_active_div", 16'(active_div), 16'(RST_DIV));
        tick(1'b1, 2'd3);
        tick(1'b0, 2'd0);
        reset = 1'b0;
    endtask

    // Monitor: compare every output against the queued prediction
    always @(negedge CLK) begin
        exp_t x;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("sel_ready", 16'(sel_ready), 16'(x.ready));
            chk("sel_done", 16'(sel_done), 16'(x.done));
            chk("active_div", 16'(active_div), 16'(x.act));
            chk("clk_out", 16'(clk_out), 16'(x.clk));
            chk("rise_pulse", 16'(rise_pulse), 16'(x.rise));
            chk("fall_pulse", 16'(fall_pulse), 16'(x.fall));
            if (sel_done === 1'b1) dut_done_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        reset     = 1'b1;
        sel_valid = 1'b0;
        div_sel   = 2'd0;
        model_reset();
        tick(1'b0, 2'd0);
        tick(1'b0, 2'd0);
        reset = 1'b0;

        // Free-running /2 after reset
        idle(8);

        // /2 -> /8 requested while clk_out is high
        i = 0;
        while (!(m_e >= half(m_code)) && i < 8) begin tick(1'b0, 2'd0); i++; end
        expect_true("reach_high_div2", m_e >= half(m_code));
        tick(1'b1, 2'd2);
        wait_applied("apply_div8", 40);
        idle(12);

        // Move to /16, then request /4 at cnt=3 of a high phase
        tick(1'b1, 2'd3);
        wait_applied("apply_div16", 40);
        i = 0;
        while (m_e != half(m_code) + 3 && i < 64) begin tick(1'b0, 2'd0); i++; end
        expect_true("reach_high_cnt3", m_e == half(m_code) + 3);
        tick(1'b1, 2'd1);
        wait_applied("apply_div4", 64);
        idle(10);

        // Requests while pending are ignored
        tick(1'b1, 2'd1);
        tick(1'b1, 2'd3);
        tick(1'b1, 2'd3);
        tick(1'b1, 2'd2);
        wait_applied("apply_same_code", 40);
        idle(6);

        // Request accepted on a falling edge with nothing pending
        i = 0;
        while (!(m_e == 2 * half(m_code) - 1 && !m_pend) && i < 32) begin tick(1'b0, 2'd0); i++; end
        expect_true("reach_fall_edge", m_e == 2 * half(m_code) - 1);
        tick(1'b1, 2'd2);
        wait_applied("apply_on_fall", 64);
        tick(1'b1, 2'd0);
        wait_applied("apply_second", 64);
        idle(6);

        // Reset while a request is pending in /8
        tick(1'b1, 2'd2);
        wait_applied("apply_div8_again", 40);
        i = 0;
        while (m_e != 1 && i < 40) begin tick(1'b0, 2'd0); i++; end
        tick(1'b1, 2'd0);
        idle(3);
        reset_mid();
        idle(10);

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            tick(($urandom % 6) == 0, 2'($urandom));
        end
        idle(40);

        @(negedge CLK);
        #1;
        chk("queue_drained", 16'(exp_q.size()), 16'd0);
        chk("sel_done_count", 16'(dut_done_cnt), 16'(exp_done_cnt));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
